fpu_add_sequencer: RTL

- Multi-cycle, FSM-sequenced IEEE-754-style floating-point add/subtract unit for the FPU.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Sequences unpack, align, add, normalize, round and pack over several cycles, then holds the result until the consumer takes it.
- Sits between the FPU operand/issue logic and the result writeback; it replaces the single-cycle combinational adder path.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_add_sequencer_if.sv | 39 +++
 rtl/fpu_round_rne.sv | 28 ++
 rtl/fpu_add_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the multi-cycle FPU adder.
// Defaults describe binary32: 1 sign, 8 exponent and 23 fraction bits.
package fpu_pkg;

    localparam int FPU_X         = 32;
    localparam int FPU_EXPO_BITS = 9;
    localparam int EXP_W         = FPU_EXPO_BITS - 1;
    localparam int FRAC_W        = FPU_X - FPU_EXPO_BITS;

    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [FPU_X-1:0] CANON_NAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

endpackage

// File: rtl/fpu_add_sequencer_if.sv
// Operand/result bus of the sequenced adder. Defining FPU_ADD_FLAGS_EN adds
// the flags vector {invalid, overflow, underflow, inexact}, valid with out_valid.
interface fpu_add_sequencer_if #(
    parameter int X = 32
);
    // Both directions use valid/ready: a beat moves on a clock edge where valid
    // and ready are both high; the sender holds its payload steady until then.
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [X-1:0] a;
    logic [X-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [X-1:0] result;

`ifdef FPU_ADD_FLAGS_EN
    logic [3:0]   flags;

    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );
    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
`else
    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, result
    );
`endif

endinterface

// File: rtl/fpu_round_rne.sv
// Combinational round-to-nearest-even on a hidden+fraction mantissa with GRS.
// The inexact output exists only when FPU_ADD_FLAGS_EN is defined.
module fpu_round_rne
    import fpu_pkg::*;
#(
    parameter int FW = FRAC_W
) (
    input  logic [FW:0] mant,
    input  logic [2:0]  grs,
    output logic [FW:0] mant_out,
    output logic        carry
`ifdef FPU_ADD_FLAGS_EN
    ,
    output logic        inexact
`endif
);

    logic round_up;

    // Round up above half, or at exactly half when the kept LSB is odd.
    assign round_up = grs[2] & (grs[1] | grs[0] | mant[0]);
    assign {carry, mant_out} = {1'b0, mant} + {{(FW+1){1'b0}}, round_up};

`ifdef FPU_ADD_FLAGS_EN
    assign inexact = |grs;
`endif

endmodule

// File: rtl/fpu_add_sequencer.sv
// Multi-cycle FSM-sequenced float add/subtract: unpack, align, add, normalize,
// round, pack. FPU_ADD_FLAGS_EN adds the exception flags output on the bus.
module fpu_add_sequencer
    import fpu_pkg::*;
#(
    parameter int X         = FPU_X,
    parameter int expo_bits = FPU_EXPO_BITS
) (
    input  logic               clk,
    input  logic               rst,
    fpu_add_sequencer_if.slave bus,
    output logic               busy,
    output state_t             dbg_state
);

    localparam int EW = expo_bits - 1;
    localparam int FW = X - expo_bits;
    // Working mantissa layout: {carry, hidden, fraction, guard, round, sticky}
    localparam int MW = FW + 5;

    localparam logic [EW-1:0] E_ONES   = '1;
    localparam logic [EW:0]   E_MAX    = {1'b0, E_ONES};
    localparam logic [EW:0]   E_ONE    = (EW+1)'(1);
    localparam logic [EW-1:0] COLLAPSE = EW'(FW + 3);
    localparam logic [X-1:0]  QNAN     = {1'b0, E_ONES, 1'b1, {(FW-1){1'b0}}};

    state_t        state;
    logic [X-1:0]  a_q, b_q, result_q;
    logic          in_ready_q, out_valid_q, busy_q;
    logic          sign_l, sign_s;
    logic [EW:0]   exp_l;
    logic [EW-1:0] diff;
    logic [MW-1:0] mant_l, mant_s;

    logic          sa, sb;
    logic [EW-1:0] ea, eb;
    logic [FW-1:0] fa, fb;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic          nan_res, special;
    logic [X-1:0]  special_res;

    assign sa = a_q[X-1];
    assign sb = b_q[X-1];
    assign ea = a_q[X-2:FW];
    assign eb = b_q[X-2:FW];
    assign fa = a_q[FW-1:0];
    assign fb = b_q[FW-1:0];

    // Exponent 0 counts as zero, so denormal inputs are flushed.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == E_ONES) && (fa == '0);
    assign b_inf  = (eb == E_ONES) && (fb == '0);
    assign a_nan  = (ea == E_ONES) && (fa != '0);
    assign b_nan  = (eb == E_ONES) && (fb != '0);

    always_comb begin
        nan_res     = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
        special     = nan_res || a_inf || b_inf || a_zero || b_zero;
        special_res = '0;
        if (nan_res)               special_res = QNAN;
        else if (a_inf)            special_res = a_q;
        else if (b_inf)            special_res = b_q;
        else if (a_zero && b_zero) special_res = {sa & sb, {(X-1){1'b0}}};
        else if (a_zero)           special_res = b_q;
        else                       special_res = a_q;
    end

    logic [FW:0]  rnd_mant, mant_r;
    logic         rnd_carry, r_ovf, r_unf;
    logic [EW:0]  exp_r;
    logic [X-1:0] round_res;
`ifdef FPU_ADD_FLAGS_EN
    logic         rnd_inexact;
`endif

    fpu_round_rne #(.FW(FW)) u_round (
        .mant     (mant_l[MW-2:3]),
        .grs      (mant_l[2:0]),
        .mant_out (rnd_mant),
`ifdef FPU_ADD_FLAGS_EN
        .inexact  (rnd_inexact),
`endif
        .carry    (rnd_carry)
    );

    // A rounding carry leaves 1.000..0 one binade up.
    always_comb begin
        exp_r  = exp_l + {{EW{1'b0}}, rnd_carry};
        mant_r = rnd_carry ? {1'b1, rnd_mant[FW:1]} : rnd_mant;
        r_ovf  = (exp_r >= E_MAX);
        r_unf  = !r_ovf && !mant_r[FW];
        if (r_ovf)      round_res = {sign_l, E_ONES, {FW{1'b0}}};
        else if (r_unf) round_res = {sign_l, {(X-1){1'b0}}};
        else            round_res = {sign_l, exp_r[EW-1:0], mant_r[FW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    a_q        <= bus.a;
                    b_q        <= {bus.b[X-1] ^ bus.op_sub, bus.b[X-2:0]};
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state      <= S_UNPACK;
                end
                S_UNPACK: if (special) begin
                    result_q    <= special_res;
                    out_valid_q <= 1'b1;
                    state       <= S_DONE;
                end else if (eb > ea) begin
                    sign_l <= sb;
                    exp_l  <= {1'b0, eb};
                    mant_l <= {2'b01, fb, 3'b000};
                    sign_s <= sa;
                    mant_s <= {2'b01, fa, 3'b000};
                    diff   <= eb - ea;
                    state  <= S_ALIGN;
                end else begin
                    sign_l <= sa;
                    exp_l  <= {1'b0, ea};
                    mant_l <= {2'b01, fa, 3'b000};
                    sign_s <= sb;
                    mant_s <= {2'b01, fb, 3'b000};
                    diff   <= ea - eb;
                    state  <= (ea == eb) ? S_ADD : S_ALIGN;
                end
                S_ALIGN: if (diff > COLLAPSE) begin
                    mant_s <= {{(MW-1){1'b0}}, |mant_s};
                    diff   <= '0;
                    state  <= S_ADD;
                end else begin
                    mant_s <= {1'b0, mant_s[MW-1:2], mant_s[1] | mant_s[0]};
                    diff   <= diff - EW'(1);
                    if (diff == EW'(1)) state <= S_ADD;
                end
                S_ADD: begin
                    state <= S_NORM;
                    if (sign_l == sign_s) begin
                        mant_l <= mant_l + mant_s;
                    end else if (mant_l == mant_s) begin
                        result_q    <= '0;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else if (mant_l > mant_s) begin
                        mant_l <= mant_l - mant_s;
                    end else begin
                        mant_l <= mant_s - mant_l;
                        sign_l <= sign_s;
                    end
                end
                S_NORM: if (mant_l[MW-1]) begin
                    mant_l <= {1'b0, mant_l[MW-1:2], mant_l[1] | mant_l[0]};
                    exp_l  <= exp_l + E_ONE;
                    state  <= S_ROUND;
                end else if (!mant_l[MW-2] && (exp_l > E_ONE)) begin
                    mant_l <= mant_l << 1;
                    exp_l  <= exp_l - E_ONE;
                end else begin
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    result_q    <= round_res;
                    out_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FPU_ADD_FLAGS_EN
    logic [3:0] flags_q;

    always_ff @(posedge clk) begin
        if (rst)                               flags_q <= '0;
        else if (state == S_IDLE && bus.in_valid) flags_q <= '0;
        else if (state == S_UNPACK && special) flags_q <= {nan_res, 3'b000};
        else if (state == S_ROUND)
            flags_q <= {1'b0, r_ovf, r_unf, rnd_inexact | r_ovf | r_unf};
    end

    assign bus.flags = flags_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign busy          = busy_q;
    assign dbg_state     = state;

endmodule
